ahb_resp_mux_n: RTL and testbench

Parametrised AHB-Lite slave-response multiplexor for the SoC interconnect; successor to the fixed 4-slave response mux.
- Captures the decoder's slave index during the address phase, gated by the bus HREADY.
- Steers HRDATA, HREADY and HRESP from N slaves to the master during the data phase.
- Contains a built-in default slave (two-cycle ERROR for unmapped accesses).
- Contains a per-transfer wait-state watchdog that aborts hung slaves with an ERROR response and an interrupt.

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_wait_watchdog.sv | 55 +++++
 rtl/ahb_resp_mux_n.sv | 144 ++++++++++++++
 tb/tb_ahb_resp_mux_n.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, response-mux FSM states and a constant
// log2 helper used to size the wait-state counter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_e;

  // Ceiling log2; returns the bit count needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_wait_watchdog.sv
// Per-transfer wait-state watchdog: counts consecutive stalled cycles of
// the selected slave and flags an abort once TIMEOUT waits have been shown.
module ahb_wait_watchdog
  import ahb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int SELW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_stall,
  input  logic [SELW-1:0] i_dsel,
  output logic            o_expire,
  output logic            o_irq,
  output logic [SELW-1:0] o_slv
);

  localparam int            CW   = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0]   r_cnt;
  logic            r_irq;
  logic [SELW-1:0] r_slv;

  // Abort on the edge where the last permitted wait is still being held.
  assign o_expire = i_stall && (r_cnt == LAST);
  assign o_irq    = r_irq;
  assign o_slv    = r_slv;

  // Wait-state counter; reaches at most TIMEOUT, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_stall) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // One-cycle interrupt and sticky record of the aborted slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
      r_slv <= '0;
    end else begin
      r_irq <= o_expire;
      if (o_expire) begin
        r_slv <= i_dsel;
      end
    end
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite slave-response multiplexor for NSLV slaves with a built-in
// default slave and an optional wait-state watchdog.
//
// state | meaning
// PASS  | steer selected slave, or idle OKAY when no data phase is active
// ERR1  | first ERROR cycle (HREADY low) after a watchdog abort
// ERR2  | second ERROR cycle (HREADY high) completing the error response
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int W       = 32,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [SELW-1:0]   hsel_idx,
  input  logic [1:0]        htrans,
  input  logic [NSLV*W-1:0] hrdata_s,
  input  logic [NSLV-1:0]   hready_s,
  input  logic [NSLV-1:0]   hresp_s,
  output logic [W-1:0]      hrdata_out,
  output logic              hready_out,
  output logic              hresp_out,
  output logic              timeout_irq,
  output logic [SELW-1:0]   timeout_slv
);

  resp_state_e     r_state;
  resp_state_e     w_state_nxt;
  logic [SELW-1:0] r_dsel;
  logic            r_dactive;
  logic            w_mapped;
  logic [W-1:0]    w_sel_rdata;
  logic            w_sel_ready;
  logic            w_sel_resp;
  logic            w_expire;

  assign w_mapped = (r_dsel < SELW'(NSLV));

  // Address-phase capture, only when the bus is advancing.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel    <= SELW'(NSLV);
      r_dactive <= 1'b0;
    end else if (hready_out) begin
      r_dsel    <= hsel_idx;
      r_dactive <= (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    end
  end

  // Pick the data-phase slave; an unmapped index yields neutral values.
  always_comb begin
    w_sel_rdata = '0;
    w_sel_ready = 1'b1;
    w_sel_resp  = HRESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel == SELW'(i)) begin
        w_sel_rdata = hrdata_s[i*W +: W];
        w_sel_ready = hready_s[i];
        w_sel_resp  = hresp_s[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and master-facing response.
  always_comb begin
    w_state_nxt = r_state;
    hready_out  = 1'b1;
    hresp_out   = HRESP_OKAY;
    hrdata_out  = '0;
    case (r_state)
      ST_PASS: begin
        if (r_dactive) begin
          if (w_mapped) begin
            hready_out = w_sel_ready;
            hresp_out  = w_sel_resp;
            hrdata_out = w_sel_rdata;
            if (w_expire) begin
              w_state_nxt = ST_ERR1;
            end
          end else begin
            // Default slave: this cycle is the first half of the ERROR pair.
            hready_out  = 1'b0;
            hresp_out   = HRESP_ERROR;
            w_state_nxt = ST_ERR2;
          end
        end
      end
      ST_ERR1: begin
        hready_out  = 1'b0;
        hresp_out   = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hready_out  = 1'b1;
        hresp_out   = HRESP_ERROR;
        w_state_nxt = ST_PASS;
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic w_stall;
      logic w_clear;

      assign w_stall = (r_state == ST_PASS) && r_dactive && w_mapped && !w_sel_ready;
      assign w_clear = hready_out || !r_dactive;

      ahb_wait_watchdog #(
        .TIMEOUT (TIMEOUT),
        .SELW    (SELW)
      ) u_wdog (
        .clk      (HCLK),
        .rst      (HRESET),
        .i_clear  (w_clear),
        .i_stall  (w_stall),
        .i_dsel   (r_dsel),
        .o_expire (w_expire),
        .o_irq    (timeout_irq),
        .o_slv    (timeout_slv)
      );
    end else begin : g_no_wdog
      assign w_expire    = 1'b0;
      assign timeout_irq = 1'b0;
      assign timeout_slv = '0;
    end
  endgenerate

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n with 4 slaves and an 8-wait watchdog.
module tb_ahb_resp_mux_n;

  localparam int NSLV = 4;
  localparam int W    = 32;
  localparam int SELW = 4;
  localparam int TOUT = 8;

  logic              HCLK;
  logic              HRESET;
  logic [SELW-1:0]   hsel_idx;
  logic [1:0]        htrans;
  logic [NSLV*W-1:0] hrdata_s;
  logic [NSLV-1:0]   hready_s;
  logic [NSLV-1:0]   hresp_s;
  logic [W-1:0]      hrdata_out;
  logic              hready_out;
  logic              hresp_out;
  logic              timeout_irq;
  logic [SELW-1:0]   timeout_slv;

  int checks   = 0;
  int failures = 0;

  logic [33:0] got;
  logic [33:0] exp;

  ahb_resp_mux_n #(
    .NSLV    (NSLV),
    .W       (W),
    .SELW    (SELW),
    .TIMEOUT (TOUT)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .hsel_idx    (hsel_idx),
    .htrans      (htrans),
    .hrdata_s    (hrdata_s),
    .hready_s    (hready_s),
    .hresp_s     (hresp_s),
    .hrdata_out  (hrdata_out),
    .hready_out  (hready_out),
    .hresp_out   (hresp_out),
    .timeout_irq (timeout_irq),
    .timeout_slv (timeout_slv)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] sdata(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic slot();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
    got = {hready_out, hresp_out, hrdata_out};
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    #3;
    got = {hready_out, hresp_out, hrdata_out};
    exp = {1'b1, 1'b0, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_out got=%h exp=%h", got, exp);
    end
    checks++;
    if ({timeout_irq, timeout_slv} !== 5'b0) begin
      failures++;
      $display("FAIL reset_wdog got irq=%0b slv=%0d exp irq=0 slv=0", timeout_irq, timeout_slv);
    end
    slot();
    slot();
    HRESET = 1'b0;
  endtask

  task automatic test_basic();
    slot();
    hsel_idx = 4'd2; htrans = 2'b10;
    slot();
    hsel_idx = 4'd0; htrans = 2'b00;
    settle();
    exp = {1'b1, 1'b0, 32'hA5A5_0002};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL basic_read got=%h exp=%h", got, exp);
    end
    slot();
    settle();
    exp = {1'b1, 1'b0, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL basic_idle got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_stall();
    slot();
    hsel_idx = 4'd1; htrans = 2'b10;
    slot();
    hready_s[1] = 1'b0; hsel_idx = 4'd0; htrans = 2'b00;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        hsel_idx = 4'd3; htrans = 2'b10;
      end
      settle();
      exp = {1'b0, 1'b0, sdata(1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stall_wait%0d got=%h exp=%h", k, got, exp);
      end
      slot();
    end
    hready_s[1] = 1'b1;
    settle();
    exp = {1'b1, 1'b0, sdata(1)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL stall_done got=%h exp=%h", got, exp);
    end
    slot();
    hsel_idx = 4'd0; htrans = 2'b00;
    settle();
    exp = {1'b1, 1'b0, sdata(3)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL stall_next_slv3 got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_unmapped();
    slot();
    hsel_idx = 4'd7; htrans = 2'b10;
    slot();
    hsel_idx = 4'd0; htrans = 2'b00;
    settle();
    exp = {1'b0, 1'b1, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL unmapped_err1 got=%h exp=%h", got, exp);
    end
    slot();
    hsel_idx = 4'd2; htrans = 2'b10;
    settle();
    exp = {1'b1, 1'b1, 32'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL unmapped_err2 got=%h exp=%h", got, exp);
    end
    slot();
    hsel_idx = 4'd0; htrans = 2'b00;
    settle();
    exp = {1'b1, 1'b0, sdata(2)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL unmapped_after got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_timeout(input int s);
    slot();
    hsel_idx = 4'(s); htrans = 2'b10;
    slot();
    hsel_idx = 4'd0; htrans = 2'b00; hready_s[s] = 1'b0;
    for (int k = 0; k < TOUT; k++) begin
      settle();
      exp = {1'b0, 1'b0, sdata(s)};
      checks++;
      if (got !== exp || timeout_irq !== 1'b0) begin
        failures++;
        $display("FAIL timeout%0d_wait%0d got=%h irq=%0b exp=%h irq=0", s, k, got, timeout_irq, exp);
      end
      slot();
    end
    settle();
    exp = {1'b0, 1'b1, 32'h0};
    checks++;
    if (got !== exp || timeout_irq !== 1'b1 || timeout_slv !== 4'(s)) begin
      failures++;
      $display("FAIL timeout%0d_err1 got=%h irq=%0b slv=%0d exp=%h irq=1 slv=%0d",
               s, got, timeout_irq, timeout_slv, exp, s);
    end
    slot();
    settle();
    exp = {1'b1, 1'b1, 32'h0};
    checks++;
    if (got !== exp || timeout_irq !== 1'b0) begin
      failures++;
      $display("FAIL timeout%0d_err2 got=%h irq=%0b exp=%h irq=0", s, got, timeout_irq, exp);
    end
    slot();
    settle();
    exp = {1'b1, 1'b0, 32'h0};
    checks++;
    if (got !== exp || timeout_irq !== 1'b0 || timeout_slv !== 4'(s)) begin
      failures++;
      $display("FAIL timeout%0d_after got=%h irq=%0b slv=%0d exp=%h irq=0 slv=%0d",
               s, got, timeout_irq, timeout_slv, exp, s);
    end
    hready_s[s] = 1'b1;
  endtask

  task automatic test_timeout_win();
    slot();
    hsel_idx = 4'd0; htrans = 2'b10;
    slot();
    htrans = 2'b00; hready_s[0] = 1'b0;
    for (int k = 0; k < TOUT - 1; k++) begin
      settle();
      exp = {1'b0, 1'b0, sdata(0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL win_wait%0d got=%h exp=%h", k, got, exp);
      end
      slot();
    end
    hready_s[0] = 1'b1;
    settle();
    exp = {1'b1, 1'b0, sdata(0)};
    checks++;
    if (got !== exp || timeout_irq !== 1'b0) begin
      failures++;
      $display("FAIL win_complete got=%h irq=%0b exp=%h irq=0", got, timeout_irq, exp);
    end
    for (int k = 0; k < 2; k++) begin
      slot();
      settle();
      exp = {1'b1, 1'b0, 32'h0};
      checks++;
      if (got !== exp || timeout_irq !== 1'b0) begin
        failures++;
        $display("FAIL win_after%0d got=%h irq=%0b exp=%h irq=0", k, got, timeout_irq, exp);
      end
    end
  endtask

  task automatic test_reset_err1();
    slot();
    hsel_idx = 4'd1; htrans = 2'b10;
    slot();
    hsel_idx = 4'd0; htrans = 2'b00; hready_s[1] = 1'b0;
    for (int k = 0; k < TOUT; k++) slot();
    settle();
    exp = {1'b0, 1'b1, 32'h0};
    checks++;
    if (got !== exp || timeout_irq !== 1'b1) begin
      failures++;
      $display("FAIL rst_err1_entry got=%h irq=%0b exp=%h irq=1", got, timeout_irq, exp);
    end
    HRESET = 1'b1;
    settle();
    exp = {1'b1, 1'b0, 32'h0};
    checks++;
    if (got !== exp || timeout_irq !== 1'b0 || timeout_slv !== 4'd0) begin
      failures++;
      $display("FAIL rst_err1_async got=%h irq=%0b slv=%0d exp=%h irq=0 slv=0",
               got, timeout_irq, timeout_slv, exp);
    end
    slot();
    slot();
    HRESET = 1'b0; hready_s[1] = 1'b1;
    hsel_idx = 4'd2; htrans = 2'b10;
    slot();
    hsel_idx = 4'd0; htrans = 2'b00;
    settle();
    exp = {1'b1, 1'b0, sdata(2)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL rst_err1_recover got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    HRESET   = 1'b1;
    hsel_idx = '0;
    htrans   = 2'b00;
    hready_s = '1;
    hresp_s  = '0;
    for (int i = 0; i < NSLV; i++) hrdata_s[i*W +: W] = sdata(i);
    test_reset();
    test_basic();
    test_stall();
    test_unmapped();
    test_timeout(3);
    test_timeout(0);
    test_timeout_win();
    test_reset_err1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
